// File: rtl/fpu_arbiter_if.sv
// Bundle of request, response and fpu-side signals between the clients, the arbiter and the shared fpu.
// The arbiter connects through the slave modport; the clients and fpu connect through the master modport.
interface fpu_arbiter_if #(
  parameter int bitness    = 32,
  parameter int requesters = 4
);
  localparam int ID_W = (requesters > 1) ? $clog2(requesters) : 1;

  logic [requesters-1:0]         req_valid;
  logic [requesters-1:0]         req_ready;
  logic [requesters*bitness-1:0] req_first;
  logic [requesters*bitness-1:0] req_second;
  logic [requesters*4-1:0]       req_command;

  logic                          resp_valid;
  logic [ID_W-1:0]               resp_id;
  logic [bitness-1:0]            resp_result;
  logic                          resp_error;

  logic                          fpu_reset;
  logic [bitness-1:0]            fpu_first;
  logic [bitness-1:0]            fpu_second;
  logic [3:0]                    fpu_command;
  logic [bitness-1:0]            fpu_result;
  logic                          fpu_work_is_done;

  logic                          busy;

  modport slave (
    input  req_valid, req_first, req_second, req_command,
    input  fpu_result, fpu_work_is_done,
    output req_ready, resp_valid, resp_id, resp_result, resp_error,
    output fpu_reset, fpu_first, fpu_second, fpu_command, busy
  );

  modport master (
    output req_valid, req_first, req_second, req_command,
    output fpu_result, fpu_work_is_done,
    input  req_ready, resp_valid, resp_id, resp_result, resp_error,
    input  fpu_reset, fpu_first, fpu_second, fpu_command, busy
  );
endinterface

// File: rtl/fpu_arbiter.sv
// Round-robin arbiter sharing one fpu between several clients, with a watchdog
// that aborts an operation whose done flag never arrives.
module fpu_arbiter #(
  parameter int bitness    = 32,
  parameter int requesters = 4,
  parameter int timeout    = 64
) (
  input  logic          clock,
  input  logic          reset_n,
  fpu_arbiter_if.slave  bus
);

  localparam int ID_W = (requesters > 1) ? $clog2(requesters) : 1;
  localparam int WD_W = $clog2(timeout) + 1;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ISSUE   = 2'd1,
    S_WAIT    = 2'd2,
    S_RESPOND = 2'd3
  } state_t;

  state_t                  r_state;
  logic [ID_W-1:0]         r_rr_ptr;
  logic [ID_W-1:0]         r_owner;
  logic [WD_W-1:0]         r_wdog;
  logic [requesters-1:0]   r_req_ready;
  logic                    r_resp_valid;
  logic [ID_W-1:0]         r_resp_id;
  logic [bitness-1:0]      r_resp_result;
  logic                    r_resp_error;
  logic                    r_fpu_reset;
  logic [bitness-1:0]      r_fpu_first;
  logic [bitness-1:0]      r_fpu_second;
  logic [3:0]              r_fpu_command;
  logic                    r_busy;

  logic [2*requesters-1:0] w_dbl;
  logic [requesters-1:0]   w_rot;
  logic [ID_W:0]           w_sum;
  logic [ID_W:0]           w_nxt;
  logic                    w_found;
  logic [ID_W-1:0]         w_winner;
  logic [ID_W-1:0]         w_rr_next;
  logic [requesters-1:0]   w_onehot;
  logic [bitness-1:0]      w_first;
  logic [bitness-1:0]      w_second;
  logic [3:0]              w_command;

  // Rotate the request vector so bit 0 is the requester at rr_ptr; the lowest set bit wins.
  always_comb begin
    w_dbl    = {bus.req_valid, bus.req_valid};
    w_rot    = requesters'(w_dbl >> r_rr_ptr);
    w_found  = 1'b0;
    w_winner = '0;
    w_sum    = '0;
    for (int k = 0; k < requesters; k++) begin
      if (!w_found && w_rot[k]) begin
        w_found = 1'b1;
        w_sum   = {1'b0, r_rr_ptr} + (ID_W+1)'(k);
        if (w_sum >= (ID_W+1)'(requesters)) begin
          w_sum = w_sum - (ID_W+1)'(requesters);
        end
        w_winner = w_sum[ID_W-1:0];
      end
    end
  end

  always_comb begin
    w_nxt = {1'b0, w_winner} + (ID_W+1)'(1);
    if (w_nxt >= (ID_W+1)'(requesters)) begin
      w_rr_next = '0;
    end else begin
      w_rr_next = w_nxt[ID_W-1:0];
    end
  end

  always_comb begin
    w_onehot  = '0;
    w_first   = '0;
    w_second  = '0;
    w_command = '0;
    for (int k = 0; k < requesters; k++) begin
      if (w_winner == ID_W'(k)) begin
        w_onehot[k] = w_found;
        w_first     = bus.req_first[k*bitness +: bitness];
        w_second    = bus.req_second[k*bitness +: bitness];
        w_command   = bus.req_command[k*4 +: 4];
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state       <= S_IDLE;
      r_rr_ptr      <= '0;
      r_owner       <= '0;
      r_wdog        <= '0;
      r_req_ready   <= '0;
      r_resp_valid  <= 1'b0;
      r_resp_id     <= '0;
      r_resp_result <= '0;
      r_resp_error  <= 1'b0;
      r_fpu_reset   <= 1'b1;
      r_fpu_first   <= '0;
      r_fpu_second  <= '0;
      r_fpu_command <= '0;
      r_busy        <= 1'b0;
    end else begin
      r_req_ready  <= '0;
      r_resp_valid <= 1'b0;
      case (r_state)
        S_IDLE: begin
          r_fpu_reset <= 1'b1;
          if (w_found) begin
            r_fpu_first   <= w_first;
            r_fpu_second  <= w_second;
            r_fpu_command <= w_command;
            r_req_ready   <= w_onehot;
            r_owner       <= w_winner;
            r_rr_ptr      <= w_rr_next;
            r_busy        <= 1'b1;
            r_state       <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          // fpu_reset stays high through this cycle so the fpu restarts on the edge that ends it.
          r_fpu_reset <= 1'b0;
          r_wdog      <= '0;
          r_state     <= S_WAIT;
        end
        S_WAIT: begin
          r_wdog <= r_wdog + 1'b1;
          if (bus.fpu_work_is_done) begin
            r_resp_result <= bus.fpu_result;
            r_resp_error  <= 1'b0;
            r_resp_id     <= r_owner;
            r_resp_valid  <= 1'b1;
            r_fpu_reset   <= 1'b1;
            r_state       <= S_RESPOND;
          end else if (r_wdog == WD_W'(timeout - 1)) begin
            r_resp_result <= '0;
            r_resp_error  <= 1'b1;
            r_resp_id     <= r_owner;
            r_resp_valid  <= 1'b1;
            r_fpu_reset   <= 1'b1;
            r_state       <= S_RESPOND;
          end
        end
        S_RESPOND: begin
          r_fpu_reset <= 1'b1;
          r_busy      <= 1'b0;
          r_state     <= S_IDLE;
        end
        default: begin
          r_fpu_reset <= 1'b1;
          r_busy      <= 1'b0;
          r_state     <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.req_ready   = r_req_ready;
  assign bus.resp_valid  = r_resp_valid;
  assign bus.resp_id     = r_resp_id;
  assign bus.resp_result = r_resp_result;
  assign bus.resp_error  = r_resp_error;
  assign bus.fpu_reset   = r_fpu_reset;
  assign bus.fpu_first   = r_fpu_first;
  assign bus.fpu_second  = r_fpu_second;
  assign bus.fpu_command = r_fpu_command;
  assign bus.busy        = r_busy;

endmodule

// File: tb/tb_fpu_arbiter.sv
// Bench for fpu_arbiter: an operation-level model of the arbiter plus a tiny fpu with
// programmable latency, checked every cycle and pinned by hand-computed expectations.
module tb_fpu_arbiter;
  localparam int BW = 32;
  localparam int NR = 4;
  localparam int TO = 64;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;
  int   lat   = 1;
  int   f_cnt = 0;

  fpu_arbiter_if #(.bitness(BW), .requesters(NR)) bus ();

  fpu_arbiter #(.bitness(BW), .requesters(NR), .timeout(TO)) dut (
    .clock   (clk),
    .reset_n (rst_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // fpu: done rises in the lat-th cycle after the restart edge; lat=0 never completes.
  always @(posedge clk) f_cnt <= bus.fpu_reset ? 0 : f_cnt + 1;
  assign bus.fpu_work_is_done = (lat != 0) && (f_cnt >= lat - 1);
  assign bus.fpu_result = (bus.fpu_command == 4'd0) ? bus.fpu_first : bus.fpu_first + bus.fpu_second;

  // Operation model: m_k counts cycles since the grant edge (0 = idle).
  int          m_k = 0;
  int          m_W = 1;
  bit          m_err = 1'b0;
  int          m_owner = 0;
  int          m_rr = 0;
  logic [31:0] m_first, m_second, m_rres;
  logic [3:0]  m_cmd;
  int          m_rid;
  bit          m_rerr;

  always @(posedge clk or negedge rst_n) begin : model
    int g;
    if (!rst_n) begin
      m_k <= 0; m_rr <= 0; m_owner <= 0; m_W <= 1; m_err <= 1'b0;
      m_first <= '0; m_second <= '0; m_cmd <= '0;
      m_rid <= 0; m_rres <= '0; m_rerr <= 1'b0;
    end else if (m_k == 0) begin
      g = -1;
      for (int o = 0; o < NR; o++)
        if (g < 0 && bus.req_valid[(m_rr + o) % NR]) g = (m_rr + o) % NR;
      if (g >= 0) begin
        m_k      <= 1;
        m_owner  <= g;
        m_rr     <= (g + 1) % NR;
        m_first  <= bus.req_first[g*BW +: BW];
        m_second <= bus.req_second[g*BW +: BW];
        m_cmd    <= bus.req_command[g*4 +: 4];
        m_W      <= (lat >= 1 && lat <= TO) ? lat : TO;
        m_err    <= !(lat >= 1 && lat <= TO);
      end
    end else if (m_k == m_W + 1) begin
      m_rid  <= m_owner;
      m_rerr <= m_err;
      m_rres <= m_err ? 32'd0 : ((m_cmd == 4'd0) ? m_first : m_first + m_second);
      m_k    <= m_k + 1;
    end else if (m_k == m_W + 2) begin
      m_k <= 0;
    end else begin
      m_k <= m_k + 1;
    end
  end

  int          gq_id[$], gq_cyc[$], rq_id[$], rq_cyc[$];
  logic [31:0] rq_res[$];
  bit          rq_err[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    chk("req_ready",   32'(bus.req_ready), (m_k == 1) ? (32'd1 << m_owner) : 32'd0);
    chk("busy",        32'(bus.busy), 32'(m_k != 0));
    chk("fpu_reset",   32'(bus.fpu_reset), 32'(!(m_k >= 2 && m_k <= m_W + 1)));
    chk("resp_valid",  32'(bus.resp_valid), 32'(m_k != 0 && m_k == m_W + 2));
    chk("resp_id",     32'(bus.resp_id), 32'(m_rid));
    chk("resp_result", bus.resp_result, m_rres);
    chk("resp_error",  32'(bus.resp_error), 32'(m_rerr));
    chk("fpu_first",   bus.fpu_first, m_first);
    chk("fpu_second",  bus.fpu_second, m_second);
    chk("fpu_command", 32'(bus.fpu_command), 32'(m_cmd));
    for (int i = 0; i < NR; i++)
      if (bus.req_ready[i]) begin gq_id.push_back(i); gq_cyc.push_back(cyc); end
    if (bus.resp_valid) begin
      rq_id.push_back(int'(bus.resp_id)); rq_res.push_back(bus.resp_result);
      rq_err.push_back(bus.resp_error);   rq_cyc.push_back(cyc);
    end
  end

  task automatic clear_log();
    gq_id.delete(); gq_cyc.delete(); rq_id.delete(); rq_cyc.delete();
    rq_res.delete(); rq_err.delete();
  endtask

  task automatic set_req(input int i, input logic [31:0] a, input logic [31:0] b, input logic [3:0] c);
    bus.req_first[i*BW +: BW]  = a;
    bus.req_second[i*BW +: BW] = b;
    bus.req_command[i*4 +: 4]  = c;
    bus.req_valid[i]           = 1'b1;
  endtask

  task automatic wait_ready(input int i);
    int n = 0;
    do begin @(negedge clk); n++; end while (!bus.req_ready[i] && n < 200);
    chk($sformatf("ready%0d_seen", i), 32'(bus.req_ready[i]), 32'd1);
    chk("issue_fpu_reset", 32'(bus.fpu_reset), 32'd1);
    bus.req_valid[i] = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    do begin @(negedge clk); n++; end while (bus.busy && n < 200);
    chk("reach_idle", 32'(bus.busy), 32'd0);
  endtask

  task automatic chk_reset(input string nm);
    chk({nm, "_req_ready"},   32'(bus.req_ready), 32'd0);
    chk({nm, "_resp_valid"},  32'(bus.resp_valid), 32'd0);
    chk({nm, "_resp_id"},     32'(bus.resp_id), 32'd0);
    chk({nm, "_resp_result"}, bus.resp_result, 32'd0);
    chk({nm, "_resp_error"},  32'(bus.resp_error), 32'd0);
    chk({nm, "_fpu_reset"},   32'(bus.fpu_reset), 32'd1);
    chk({nm, "_fpu_first"},   bus.fpu_first, 32'd0);
    chk({nm, "_fpu_second"},  bus.fpu_second, 32'd0);
    chk({nm, "_fpu_command"}, 32'(bus.fpu_command), 32'd0);
    chk({nm, "_busy"},        32'(bus.busy), 32'd0);
  endtask

  task automatic check_op(input string nm, input int id, input logic [31:0] res, input bit err, input int dly);
    chk({nm, "_ngrant"}, 32'(gq_id.size()), 32'd1);
    chk({nm, "_nresp"},  32'(rq_id.size()), 32'd1);
    if (gq_id.size() > 0 && rq_id.size() > 0) begin
      chk({nm, "_grant_id"}, 32'(gq_id[0]), 32'(id));
      chk({nm, "_resp_id"},  32'(rq_id[0]), 32'(id));
      chk({nm, "_result"},   rq_res[0], res);
      chk({nm, "_error"},    32'(rq_err[0]), 32'(err));
      chk({nm, "_latency"},  32'(rq_cyc[0] - gq_cyc[0]), 32'(dly));
    end
  endtask

  task automatic do_reset();
    @(negedge clk); rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: got time %0t required finish before 500000", $time);
    $fatal(1);
  end

  initial begin
    int n;
    bus.req_valid = '0; bus.req_first = '0; bus.req_second = '0; bus.req_command = '0;
    lat = 2;
    #1 rst_n = 1'b0;
    #2 chk_reset("por");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Single request, fpu latency 2.
    clear_log(); lat = 2;
    set_req(2, 32'h4040_0000, 32'h3F80_0000, 4'd0);
    wait_ready(2); wait_idle();
    check_op("single", 2, 32'h4040_0000, 1'b0, 3);

    // Round robin from a fresh reset, all four requesting, latency 1.
    do_reset(); clear_log(); lat = 1;
    for (int i = 0; i < NR; i++) set_req(i, 32'h0100_0000 << i, 32'(i + 5), 4'(i));
    n = 0;
    while (gq_id.size() < 5 && n < 80) begin @(negedge clk); n++; end
    bus.req_valid = '0;
    wait_idle();
    chk("rr_ngrant", 32'(gq_id.size()), 32'd5);
    if (gq_id.size() == 5) begin
      chk("rr_g0", 32'(gq_id[0]), 32'd0); chk("rr_g1", 32'(gq_id[1]), 32'd1);
      chk("rr_g2", 32'(gq_id[2]), 32'd2); chk("rr_g3", 32'(gq_id[3]), 32'd3);
      chk("rr_g4", 32'(gq_id[4]), 32'd0);
      for (int i = 1; i < 5; i++) chk("rr_spacing", 32'(gq_cyc[i] - gq_cyc[i-1]), 32'd4);
    end
    if (rq_res.size() > 1) chk("rr_res1", rq_res[1], 32'h0200_0006);

    // Timeout, then a normal operation afterwards.
    clear_log(); lat = 0;
    set_req(1, 32'hDEAD_0000, 32'd1, 4'd2);
    wait_ready(1); wait_idle();
    check_op("timeout", 1, 32'd0, 1'b1, 65);
    clear_log(); lat = 3;
    set_req(3, 32'h10, 32'h20, 4'd1);
    wait_ready(3); wait_idle();
    check_op("after_to", 3, 32'h30, 1'b0, 4);

    // Done arrives on the final watchdog cycle.
    clear_log(); lat = 64;
    set_req(0, 32'h1111_1111, 32'd2, 4'd0);
    wait_ready(0); wait_idle();
    check_op("last_cycle", 0, 32'h1111_1111, 1'b0, 65);

    // Async reset mid-WAIT; rr_ptr was 2 after granting requester 1.
    clear_log(); lat = 0;
    set_req(1, 32'hA5A5_A5A5, 32'd3, 4'd1);
    wait_ready(1);
    repeat (10) @(negedge clk);
    @(posedge clk); #2 rst_n = 1'b0;
    #1 chk_reset("async");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (80) @(negedge clk);
    chk("no_resp_after_reset", 32'(rq_id.size()), 32'd0);
    clear_log(); lat = 2;
    set_req(0, 32'd7, 32'd8, 4'd1);
    set_req(2, 32'd9, 32'd10, 4'd1);
    wait_ready(0); wait_ready(2); wait_idle();
    chk("post_rst_ngrant", 32'(gq_id.size()), 32'd2);
    if (gq_id.size() == 2) begin
      chk("post_rst_first", 32'(gq_id[0]), 32'd0);
      chk("post_rst_second", 32'(gq_id[1]), 32'd2);
    end
    if (rq_res.size() == 2) begin
      chk("post_rst_res0", rq_res[0], 32'd15);
      chk("post_rst_res1", rq_res[1], 32'd19);
    end

    // Withdrawn request: requester 1 pulses while busy, requester 3 holds.
    clear_log(); lat = 5;
    set_req(0, 32'd1, 32'd2, 4'd1);
    wait_ready(0);
    @(negedge clk);
    set_req(1, 32'h55, 32'h1, 4'd1);
    set_req(3, 32'h30, 32'h3, 4'd1);
    repeat (2) @(negedge clk);
    bus.req_valid[1] = 1'b0;
    wait_idle();
    wait_ready(3); wait_idle();
    repeat (10) @(negedge clk);
    chk("wd_ngrant", 32'(gq_id.size()), 32'd2);
    chk("wd_nresp",  32'(rq_id.size()), 32'd2);
    if (gq_id.size() == 2) chk("wd_grant1", 32'(gq_id[1]), 32'd3);
    if (rq_id.size() == 2) begin
      chk("wd_resp1_id", 32'(rq_id[1]), 32'd3);
      chk("wd_resp1_res", rq_res[1], 32'h33);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
